// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode freeze from shadow EXE/MEM/WB dest slots plus saturating stall counter; define HAZARD_FORWARDING_EN for load-use-only detection
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int STALL_CNT_W = 16,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  src1,
  input  logic [REG_ADDR_W-1:0]  src2,
  input  logic                   src2_check,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_wb_en,
  input  logic                   id_mem_read,
  input  logic                   flush,
  output logic                   freeze,
  output logic [STALL_CNT_W-1:0] stall_count
);
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dest;
  } slot_t;
  slot_t exe, mem, wb;
  logic hit_exe, hit_mem, hit_wb, hazard, unused_ok;
  assign hit_exe = exe.wb_en && exe.dest != '0 && (exe.dest == src1 || (src2_check && exe.dest == src2));
  assign hit_mem = mem.wb_en && mem.dest != '0 && (mem.dest == src1 || (src2_check && mem.dest == src2));
  assign hit_wb  = wb.wb_en  && wb.dest  != '0 && (wb.dest  == src1 || (src2_check && wb.dest  == src2));
`ifdef HAZARD_FORWARDING_EN
  assign hazard = hit_exe && exe.mem_read;
  assign unused_ok = ^{hit_mem, hit_wb, wb.mem_read, 1'(WB_BYPASS)};
`else
  assign hazard = hit_exe || hit_mem || (!WB_BYPASS && hit_wb);
  assign unused_ok = ^{exe.mem_read, wb.mem_read};
`endif
  assign freeze = hazard && !flush;
  // shift the shadow pipeline, inserting a bubble when decode is frozen or killed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exe <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      wb  <= mem;
      mem <= exe;
      exe <= (freeze || flush) ? '0 : slot_t'{id_wb_en, id_mem_read, id_dest};
    end
  // count frozen cycles, holding at all-ones
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_count <= '0;
    else if (freeze && stall_count != '1) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against a history-based model
module tb_hazard_scoreboard;
  localparam bit WB_BYPASS_TB = 1'b1;
`ifdef HAZARD_FORWARDING_EN
  localparam int ADD_STALL = 0, LOAD_STALL = 1, MEM_ONLY_STALL = 0;
`else
  localparam int ADD_STALL = WB_BYPASS_TB ? 2 : 3, LOAD_STALL = ADD_STALL, MEM_ONLY_STALL = WB_BYPASS_TB ? 1 : 2;
`endif
  typedef struct packed {
    logic       wb;
    logic       mr;
    logic [4:0] dest;
  } ent_t;
  logic clk = 0, rst = 1;
  logic [4:0] src1 = 0, src2 = 0, id_dest = 0;
  logic src2_check = 0, id_wb_en = 0, id_mem_read = 0, flush = 0;
  logic freeze, freeze2;
  logic [15:0] stall_count;
  logic [1:0] stall_count2;
  int total = 0, bad = 0;
  ent_t hist[$];
  int cnt_m = 0, cnt_s = 0;
  logic f_obs, f_exp;
  always #5 clk = ~clk;
  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src2_check(src2_check),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .flush(flush),
    .freeze(freeze), .stall_count(stall_count)
  );
  hazard_scoreboard #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src2_check(src2_check),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .flush(flush),
    .freeze(freeze2), .stall_count(stall_count2)
  );
  function automatic bit reads(ent_t e, logic [4:0] s1, logic [4:0] s2, logic c2);
    return e.wb && e.dest != 0 && (e.dest == s1 || (c2 && e.dest == s2));
  endfunction
  // hist[0] is the instruction that entered execute most recently
  function automatic bit model_freeze(logic [4:0] s1, logic [4:0] s2, logic c2, logic fl);
    bit h = 0;
    for (int age = 0; age < 3 && age < hist.size(); age++) begin
`ifdef HAZARD_FORWARDING_EN
      if (age == 0 && hist[0].mr && reads(hist[0], s1, s2, c2)) h = 1;
`else
      if (reads(hist[age], s1, s2, c2) && (age < 2 || !WB_BYPASS_TB)) h = 1;
`endif
    end
    return h && !fl;
  endfunction
  task automatic cycle(input logic [4:0] s1, input logic [4:0] s2, input logic c2,
                       input logic [4:0] d, input logic w, input logic mr, input logic fl);
    ent_t e;
    @(negedge clk);
    src1 = s1; src2 = s2; src2_check = c2; id_dest = d; id_wb_en = w; id_mem_read = mr; flush = fl;
    #1;
    f_obs = freeze;
    f_exp = model_freeze(s1, s2, c2, fl);
    @(posedge clk);
    e = (f_exp || fl) ? ent_t'(0) : ent_t'{w, mr, d};
    hist.push_front(e);
    if (hist.size() > 3) void'(hist.pop_back());
    if (f_exp) begin
      if (cnt_m < 65535) cnt_m++;
      if (cnt_s < 3) cnt_s++;
    end
  endtask
  task automatic hold(input logic [4:0] s1, input logic [4:0] s2, input logic c2,
                      output int n_obs, output int n_exp);
    n_obs = 0; n_exp = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(s1, s2, c2, 5'd9, 1'b1, 1'b0, 1'b0);
      n_obs += int'(f_obs);
      n_exp += int'(f_exp);
      if (!f_obs && !f_exp) break;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    hist.delete();
    cnt_m = 0; cnt_s = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL reset_freeze got=%b want=0", freeze); end
    cycle(0, 0, 0, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    src1 = 5'd3; src2_check = 0; flush = 0; id_wb_en = 0;
    #1;
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL stale_pre_rst got=%b want=1", freeze); end
    #2 rst = 1;
    #1;
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL async_rst_freeze got=%b want=0", freeze); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL async_rst_count got=%0d want=0", stall_count); end
    hist.delete();
    cnt_m = 0; cnt_s = 0;
    @(negedge clk);
    rst = 0;
    cycle(5'd3, 0, 0, 0, 0, 0, 0);
    total++; if (f_obs !== 1'b0) begin bad++; $display("FAIL post_rst_read got=%b want=0", f_obs); end
  endtask
  task automatic test_raw_exe();
    int n_obs, n_exp, c0;
    drain();
    #1 c0 = int'(stall_count);
    cycle(0, 0, 0, 5'd3, 1'b1, 1'b0, 1'b0);
    hold(5'd3, 0, 0, n_obs, n_exp);
    total++; if (n_obs !== ADD_STALL) begin bad++; $display("FAIL raw_exe_stalls got=%0d want=%0d", n_obs, ADD_STALL); end
    total++; if (n_obs !== n_exp) begin bad++; $display("FAIL raw_exe_model got=%0d want=%0d", n_obs, n_exp); end
    #1;
    total++; if (int'(stall_count) !== c0 + ADD_STALL) begin bad++; $display("FAIL raw_exe_count got=%0d want=%0d", stall_count, c0 + ADD_STALL); end
  endtask
  task automatic test_src2_gating();
    int n_obs, n_exp;
    drain();
    cycle(0, 0, 0, 5'd5, 1'b1, 1'b1, 1'b0);
    hold(5'd1, 5'd5, 1'b0, n_obs, n_exp);
    total++; if (n_obs !== 0) begin bad++; $display("FAIL src2_unchecked got=%0d want=0", n_obs); end
    drain();
    cycle(0, 0, 0, 5'd5, 1'b1, 1'b1, 1'b0);
    hold(5'd1, 5'd5, 1'b1, n_obs, n_exp);
    total++; if (n_obs !== LOAD_STALL) begin bad++; $display("FAIL src2_checked got=%0d want=%0d", n_obs, LOAD_STALL); end
  endtask
  task automatic test_reg_zero();
    int n_obs, n_exp, c0;
    drain();
    #1 c0 = int'(stall_count);
    cycle(0, 0, 0, 5'd0, 1'b1, 1'b1, 1'b0);
    hold(5'd0, 5'd0, 1'b1, n_obs, n_exp);
    total++; if (n_obs !== 0) begin bad++; $display("FAIL reg_zero_stalls got=%0d want=0", n_obs); end
    #1;
    total++; if (int'(stall_count) !== c0) begin bad++; $display("FAIL reg_zero_count got=%0d want=%0d", stall_count, c0); end
  endtask
  task automatic test_flush();
    int n_obs, n_exp, c0;
    drain();
    #1 c0 = int'(stall_count);
    cycle(0, 0, 0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle(5'd7, 0, 0, 5'd8, 1'b1, 1'b0, 1'b1);
    total++; if (f_obs !== 1'b0) begin bad++; $display("FAIL flush_freeze got=%b want=0", f_obs); end
    #1;
    total++; if (int'(stall_count) !== c0) begin bad++; $display("FAIL flush_count got=%0d want=%0d", stall_count, c0); end
    hold(5'd8, 5'd7, 1'b1, n_obs, n_exp);
    total++; if (n_obs !== MEM_ONLY_STALL) begin bad++; $display("FAIL flush_next got=%0d want=%0d", n_obs, MEM_ONLY_STALL); end
  endtask
  task automatic test_saturate();
    int n_obs, n_exp;
    do_reset();
    cycle(0, 0, 0, 5'd4, 1'b1, 1'b1, 1'b0);
    hold(5'd4, 0, 0, n_obs, n_exp);
    total++; if (n_obs !== LOAD_STALL) begin bad++; $display("FAIL load_use_stalls got=%0d want=%0d", n_obs, LOAD_STALL); end
    #1;
    total++; if (int'(stall_count2) !== LOAD_STALL) begin bad++; $display("FAIL sat_first got=%0d want=%0d", stall_count2, LOAD_STALL); end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 5'd4, 1'b1, 1'b1, 1'b0);
      hold(5'd4, 0, 0, n_obs, n_exp);
    end
    #1;
    total++; if (stall_count2 !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d want=3", stall_count2); end
    total++; if (int'(stall_count) !== 4 * LOAD_STALL) begin bad++; $display("FAIL sat_wide got=%0d want=%0d", stall_count, 4 * LOAD_STALL); end
  endtask
  task automatic test_random();
    logic [4:0] s1, s2, d;
    logic c2, w, mr, fl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s1 = 5'($urandom_range(0, 3)); s2 = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 3));
      c2 = 1'($urandom); w = ($urandom_range(0, 3) != 0); mr = 1'($urandom); fl = ($urandom_range(0, 9) == 0);
      cycle(s1, s2, c2, d, w, mr, fl);
      total++; if (f_obs !== f_exp) begin bad++; $display("FAIL rand_freeze i=%0d got=%b want=%b", i, f_obs, f_exp); end
      total++; if (freeze2 !== f_exp) begin bad++; $display("FAIL rand_freeze2 i=%0d got=%b want=%b", i, freeze2, f_exp); end
      #1;
      total++; if (int'(stall_count) !== cnt_m) begin bad++; $display("FAIL rand_count i=%0d got=%0d want=%0d", i, stall_count, cnt_m); end
      total++; if (int'(stall_count2) !== cnt_s) begin bad++; $display("FAIL rand_count2 i=%0d got=%0d want=%0d", i, stall_count2, cnt_s); end
    end
  endtask
  initial begin
    test_reset();
    test_raw_exe();
    test_src2_gating();
    test_reg_zero();
    test_flush();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
